ps2_keyboard_receiver: RTL and testbench

PS2_KEYBOARD_RECEIVER -- requirements
Module: ps2_keyboard_receiver

---
 rtl/ps2_keyboard_receiver.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_receiver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_receiver.sv
// ps2_keyboard_receiver
//   Receive-only PS/2 keyboard interface. The raw PS/2 clock and data pins are
//   synchronized, the clock is glitch-filtered, and each falling edge of the
//   filtered clock samples one frame bit (start, 8 data LSB first, odd parity,
//   stop). Completed bytes land in a one-entry holding register with a
//   valid/ready handshake.
//
//   Optional feature macro: PS2_PARITY_CHECK_EN
//     defined   -> frames failing odd parity pulse parity_error and are dropped
//     undefined -> the parity bit is sampled and ignored, parity_error = 0
//
// Ports
//   clock        system clock, all state on its rising edge
//   reset_n      asynchronous active-low reset
//   ps2_clk      raw PS/2 clock pin (input only)
//   ps2_dat      raw PS/2 data pin (input only)
//   rx_data      received byte, meaningful while rx_valid = 1
//   rx_valid     holding register full
//   rx_ready     consumer accepts rx_data when rx_valid & rx_ready
//   busy         a frame is in progress
//   frame_error  1-cycle pulse: bad stop bit or inter-edge timeout
//   parity_error 1-cycle pulse: parity failure (checking build only)
//   overrun      1-cycle pulse: completed byte dropped, register still full
module ps2_keyboard_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_error,
  output logic       parity_error,
  output logic       overrun
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // synchronizers
  logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;

  // clock filter
  logic [FCW-1:0] flt_cnt_q, flt_cnt_d;
  logic           flt_clk_q, flt_clk_d;
  logic           fall;

  // frame state
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           tmo_hit;
  logic           done;

  // outputs
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_error_q, frame_error_d;
  logic       overrun_q, overrun_d;
`ifdef PS2_PARITY_CHECK_EN
  logic       par_q, par_d;
  logic       parity_error_q, parity_error_d;
`endif

  // Filter: the filtered level follows the synchronized clock only after it
  // has disagreed for FILTER_LEN consecutive samples; any agreeing sample
  // restarts the count, so short glitches never get through.
  always_comb begin
    flt_cnt_d = '0;
    flt_clk_d = flt_clk_q;
    if (clk_sync_q != flt_clk_q) begin
      if (flt_cnt_q == FCW'(FILTER_LEN - 1)) flt_clk_d = clk_sync_q;
      else                                   flt_cnt_d = flt_cnt_q + FCW'(1);
    end
  end

  // Sampling event is the cycle in which the filtered clock drops; data is
  // taken from the synchronizer in that same cycle.
  assign fall = flt_clk_q & ~flt_clk_d;

  assign tmo_hit = (state_q != IDLE) && !fall &&
                   (tmo_q == TCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    tmo_d         = tmo_q + TCW'(1);
    done          = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_ready;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d          = par_q;
    parity_error_d = 1'b0;
`endif

    if (state_q == IDLE || fall || tmo_hit) tmo_d = '0;

    case (state_q)
      IDLE: begin
        if (fall && !dat_sync_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_sync_q;
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!dat_sync_q) begin
            frame_error_d = 1'b1;
          end else begin
`ifdef PS2_PARITY_CHECK_EN
            // odd parity: data plus parity must hold an odd number of ones
            if (^{shift_q, par_q}) done = 1'b1;
            else                   parity_error_d = 1'b1;
`else
            done = 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d       = IDLE;
      frame_error_d = 1'b1;
    end

    // A byte is taken if the register is empty or is being drained this
    // same cycle; otherwise the old byte wins and the new one is dropped.
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q    <= 1'b1;
      clk_sync_q    <= 1'b1;
      dat_meta_q    <= 1'b1;
      dat_sync_q    <= 1'b1;
      flt_cnt_q     <= '0;
      flt_clk_q     <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      tmo_q         <= '0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q          <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      clk_meta_q    <= ps2_clk;
      clk_sync_q    <= clk_meta_q;
      dat_meta_q    <= ps2_dat;
      dat_sync_q    <= dat_meta_q;
      flt_cnt_q     <= flt_cnt_d;
      flt_clk_q     <= flt_clk_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      tmo_q         <= tmo_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q          <= par_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
`ifdef PS2_PARITY_CHECK_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Bench for ps2_keyboard_receiver: directed frames followed by random frames.
// A frame-level model predicts the ordered list of observable events
// (handshake with data, frame_error, parity_error, overrun); a monitor checks
// every observed event against that list on each cycle.
module tb_ps2_keyboard_receiver;

  localparam int FLT = 8;
  localparam int TMO = 3000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_error, parity_error, overrun;

  ps2_keyboard_receiver #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy),
    .frame_error(frame_error), .parity_error(parity_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  localparam int EV_DATA = 0, EV_FERR = 1, EV_PERR = 2, EV_OVR = 3;
  typedef struct { int kind; logic [7:0] data; } ev_t;

  ev_t        exp_q[$];
  bit         hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  logic [7:0] last_rx = 8'h00;
  int         nvec = 0;
  int         nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // odd parity bit: set when the data byte has an even count of ones
  function automatic logic oddpar(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return (n % 2 == 0);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // model: outcome of one complete frame given the current rx_ready level
  task automatic expect_frame(input logic [7:0] d, input logic p, input logic s);
    ev_t e;
    e.data = d;
    if (!s) begin
      e.kind = EV_FERR; exp_q.push_back(e);
    end else if (PAR_EN && (p != oddpar(d))) begin
      e.kind = EV_PERR; exp_q.push_back(e);
    end else if (rx_ready) begin
      e.kind = EV_DATA; exp_q.push_back(e);
    end else if (hold_v) begin
      e.kind = EV_OVR; exp_q.push_back(e);
    end else begin
      hold_v = 1'b1; hold_d = d;
    end
  endtask

  task automatic set_ready(input logic r);
    ev_t e;
    if (r && hold_v) begin
      e.kind = EV_DATA; e.data = hold_d; exp_q.push_back(e);
      hold_v = 1'b0;
    end
    rx_ready = r;
  endtask

  task automatic push_ferr;
    ev_t e;
    e.kind = EV_FERR; e.data = 8'h00; exp_q.push_back(e);
  endtask

  task automatic got_ev(input int k, input logic [7:0] d);
    ev_t e;
    nvec++;
    if (exp_q.size() == 0) begin
      nerr++;
      $display("FAIL event: got kind %0d data %0h, required no event", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_DATA && e.data !== d)) begin
        nerr++;
        $display("FAIL event: got kind %0d data %0h, required kind %0d data %0h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  // monitor: inputs change 1 time unit after posedge, so negedge is stable
  always @(negedge clock) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        got_ev(EV_DATA, rx_data);
        last_rx = rx_data;
      end
      if (frame_error)  got_ev(EV_FERR, 8'h00);
      if (parity_error) got_ev(EV_PERR, 8'h00);
      if (overrun)      got_ev(EV_OVR, 8'h00);
    end
  end

  // Drives the first nbits of a frame; glitch adds a 3-cycle low pulse in
  // the middle of every clock-high phase.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    int half;
    bits = {s, p, d, 1'b0};
    half = $urandom_range(30, 60);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      for (int j = 0; j < half; j++) begin
        if (glitch && j == half / 2)     ps2_clk = 1'b0;
        if (glitch && j == half / 2 + 3) ps2_clk = 1'b1;
        tick;
      end
      ps2_clk = 1'b0;
      repeat (half) tick;
      if (i == 0) chk("busy_mid", busy, 1);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (60) tick;
    chk("drain", exp_q.size(), 0);
    if (nbits == 11) chk("busy_idle", busy, 0);
  endtask

  task automatic good_frame(input logic [7:0] d, input bit glitch);
    expect_frame(d, oddpar(d), 1'b1);
    send_frame(d, oddpar(d), 1'b1, 11, glitch);
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_parity_error", parity_error, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    repeat (5) tick;

    chk("oddpar_1c", oddpar(8'h1C), 0);
    chk("oddpar_f0", oddpar(8'hF0), 1);

    // single good frame
    set_ready(1'b1);
    expect_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("byte_1c", last_rx, 8'h1C);

    // wrong parity bit
    expect_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    chk("rx_valid_after_par", rx_valid, 0);

    // overrun with consumer stalled
    set_ready(1'b0);
    good_frame(8'hF0, 1'b0);
    good_frame(8'h1C, 1'b0);
    chk("held_data", rx_data, 8'hF0);
    chk("held_valid", rx_valid, 1);
    set_ready(1'b1);
    repeat (2) tick;
    chk("consumed_valid", rx_valid, 0);
    chk("consumed_byte", last_rx, 8'hF0);

    // timeout on a partial frame, then a clean frame
    send_frame(8'h05, 1'b0, 1'b1, 5, 1'b0);
    push_ferr();
    repeat (TMO + 100) tick;
    chk("timeout_drain", exp_q.size(), 0);
    chk("timeout_busy", busy, 0);
    good_frame(8'h5A, 1'b0);
    chk("byte_5a", last_rx, 8'h5A);

    // filtered glitches, then bad stop bit
    good_frame(8'h29, 1'b1);
    chk("byte_29", last_rx, 8'h29);
    expect_frame(8'h29, oddpar(8'h29), 1'b0);
    send_frame(8'h29, oddpar(8'h29), 1'b0, 11, 1'b1);
    chk("stop0_valid", rx_valid, 0);

    // reset in the middle of a frame
    send_frame(8'h76, 1'b0, 1'b1, 6, 1'b0);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_errs", {frame_error, parity_error, overrun}, 0);
    hold_v = 1'b0;
    repeat (3) tick;
    reset_n = 1'b1;
    repeat (5) tick;
    good_frame(8'h76, 1'b0);
    chk("byte_76", last_rx, 8'h76);

    // random frames
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic p, s;
      d = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      p = ($urandom_range(0, 5) == 0) ? ~oddpar(d) : oddpar(d);
      set_ready(1'($urandom_range(0, 1)));
      expect_frame(d, p, s);
      send_frame(d, p, s, 11, 1'($urandom_range(0, 1)));
    end

    set_ready(1'b1);
    repeat (5) tick;
    chk("final_drain", exp_q.size(), 0);
    chk("final_valid", rx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
